// File: rtl/pipe_pkg.sv
// Shared constants for the core pipeline-stage registers: skid FSM state encodings and the F/ID bubble instruction.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // addi x0, x0, 0 -- the canonical RISC-V NOP used as the F/ID bubble
  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; 1-cycle update, clear wins over increment, never wraps.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with 2-entry skid: 1-cycle latency, 1 beat/cycle, flush inserts a bubble.
// i_ready depends only on state, i_stall and i_flush, so upstream never sees o_ready combinationally.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               DATA_W     = 64,
  parameter logic [DATA_W-1:0] RST_VAL    = '0,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              o_ready,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_cnt_clr,
  output logic [1:0]        o_count,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign i_ready  = (state_q != ST_FULL) & ~i_stall & ~i_flush;
  assign o_valid  = (state_q != ST_EMPTY);
  assign in_fire  = i_valid & i_ready;
  assign out_fire = o_valid & o_ready & ~i_stall;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = i_data;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (in_fire) begin
            skid_d  = i_data;
            state_d = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_data  = main_q;
  assign o_count = state_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(i_stall | (o_valid & ~o_ready)),
    .clr(i_cnt_clr),
    .q  (o_stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: scoreboard queue fed by the driver, drained by an output monitor.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int DATA_W = 64;
  localparam logic [63:0] RST_V = 64'h0000_00AA_0000_00BB;
  localparam logic [63:0] BUB_V = {32'h0, PIPE_NOP};

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_stall, i_flush, i_cnt_clr;
  logic [63:0] i_data;
  logic        i_ready, o_valid;
  logic [63:0] o_data;
  logic [1:0]  o_count;
  logic [15:0] o_stall_cnt;
  logic        i_ready4, o_valid4;
  logic [63:0] o_data4;
  logic [1:0]  o_count4;
  logic [3:0]  o_stall_cnt4;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DATA_W), .RST_VAL(RST_V), .BUBBLE_VAL(BUB_V), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready), .i_stall(i_stall),
    .i_flush(i_flush), .i_cnt_clr(i_cnt_clr), .o_count(o_count), .o_stall_cnt(o_stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(DATA_W), .RST_VAL(RST_V), .BUBBLE_VAL(BUB_V), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready4),
    .o_valid(o_valid4), .o_data(o_data4), .o_ready(o_ready), .i_stall(i_stall),
    .i_flush(i_flush), .i_cnt_clr(i_cnt_clr), .o_count(o_count4), .o_stall_cnt(o_stall_cnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every beat the downstream takes must be the oldest expected one
  always @(negedge clk) begin
    if (rst && o_valid && o_ready && !i_stall && !i_flush) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h expected none", o_data);
      end else begin
        chk("order", o_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_valid = 1'b1; i_data = 64'h55; o_ready = 1'b1;
    i_stall = 1'b0; i_flush = 1'b0; i_cnt_clr = 1'b0;

    // 1. reset
    step(); step(); smp();
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_o_count", {62'd0, o_count}, 64'd0);
    chk("rst_stall_cnt", {48'd0, o_stall_cnt}, 64'd0);
    chk("rst_o_data", o_data, RST_V);
    step(); rst = 1'b1; i_valid = 1'b0;
    smp();
    chk("rst_i_ready", {63'd0, i_ready}, 64'd1);

    // 2. streaming 1..8
    step();
    i_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_data = 64'(k);
      smp();
      chk("stream_i_ready", {63'd0, i_ready}, 64'd1);
      exp_q.push_back(64'(k));
      if (k >= 2) begin
        chk("stream_o_valid", {63'd0, o_valid}, 64'd1);
        chk("stream_o_count", {62'd0, o_count}, 64'd1);
        chk("stream_latency", o_data, 64'(k - 1));
      end
      step();
    end
    i_valid = 1'b0;
    smp();
    chk("stream_last", o_data, 64'd8);
    step(); smp();
    chk("stream_drained", {63'd0, o_valid}, 64'd0);

    // 3. backpressure
    step();
    i_valid = 1'b1; i_data = 64'hA;
    smp(); exp_q.push_back(64'hA);
    step();
    o_ready = 1'b0; i_data = 64'hB;
    smp(); exp_q.push_back(64'hB);
    step();
    i_data = 64'hC;
    smp();
    chk("bp_o_count", {62'd0, o_count}, 64'd2);
    chk("bp_i_ready", {63'd0, i_ready}, 64'd0);
    chk("bp_hold_a", o_data, 64'hA);
    step();
    i_valid = 1'b0; o_ready = 1'b1;
    smp();
    chk("bp_first_a", o_data, 64'hA);
    step(); smp();
    chk("bp_then_b", o_data, 64'hB);
    chk("bp_count_1", {62'd0, o_count}, 64'd1);
    step();

    // 4. flush while FULL
    o_ready = 1'b0; i_valid = 1'b1; i_data = 64'h21;
    step();
    i_data = 64'h22;
    step();
    smp();
    chk("fl_full", {62'd0, o_count}, 64'd2);
    step();
    i_flush = 1'b1; i_data = 64'h99;
    smp();
    chk("fl_i_ready", {63'd0, i_ready}, 64'd0);
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    smp();
    chk("fl_o_valid", {63'd0, o_valid}, 64'd0);
    chk("fl_o_count", {62'd0, o_count}, 64'd0);
    chk("fl_bubble", o_data, BUB_V);
    step(); smp();
    chk("fl_no_accept", {63'd0, o_valid}, 64'd0);
    step();
    o_ready = 1'b1;

    // 5. stall while BUSY
    i_cnt_clr = 1'b1; i_valid = 1'b1; i_data = 64'h77;
    smp(); exp_q.push_back(64'h77);
    step();
    i_cnt_clr = 1'b0; i_valid = 1'b0; i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("stall_o_valid", {63'd0, o_valid}, 64'd1);
      chk("stall_o_data", o_data, 64'h77);
      chk("stall_i_ready", {63'd0, i_ready}, 64'd0);
      step();
    end
    i_stall = 1'b0;
    smp();
    chk("stall_cnt_5", {48'd0, o_stall_cnt}, 64'd5);
    step();
    i_cnt_clr = 1'b1;
    step();
    i_cnt_clr = 1'b0;
    smp();
    chk("stall_cnt_clr", {48'd0, o_stall_cnt}, 64'd0);

    // 6. saturation on the 4-bit counter
    step();
    i_cnt_clr = 1'b1;
    step();
    i_cnt_clr = 1'b0; i_stall = 1'b1;
    repeat (20) @(posedge clk);
    #1; smp();
    chk("sat_15", {60'd0, o_stall_cnt4}, 64'd15);
    chk("wide_20", {48'd0, o_stall_cnt}, 64'd20);
    repeat (3) @(posedge clk);
    #1; smp();
    chk("sat_hold", {60'd0, o_stall_cnt4}, 64'd15);
    step();
    i_cnt_clr = 1'b1;
    step();
    i_cnt_clr = 1'b0; i_stall = 1'b0;
    smp();
    chk("clr_over_inc", {60'd0, o_stall_cnt4}, 64'd0);

    step(); step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
